// File: rtl/ksa_swap_fsm_pkg.sv
// ----------------------------------------------------------------------------
// ksa_swap_fsm_pkg
// Shared RC4 definitions used by the S-init, key-schedule (swap) and PRGA
// controllers.
//   S_DEPTH         number of entries in the RC4 state array S
//   KEY_BYTES_DFLT  default secret key length in bytes
//   ksa_state_t     key-schedule FSM state encoding
//   idx_width()     width of a 0..n-1 index, never narrower than one bit
// ----------------------------------------------------------------------------
package ksa_swap_fsm_pkg;

  localparam int S_DEPTH        = 256;
  localparam int KEY_BYTES_DFLT = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    CAP_SI,
    RD_SJ,
    CAP_SJ,
    WR_I,
    WR_J,
    NXT,
    DONE
  } ksa_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ksa_swap_fsm_key_byte_sel.sv
// ----------------------------------------------------------------------------
// ksa_swap_fsm_key_byte_sel
// Walks the latched secret key one byte per RC4 iteration. Keeps a
// mod-KEY_BYTES index (plain wrap compare, no divider) and muxes out the
// selected byte; byte 0 is the most significant byte of the key.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (index to 0)
//   i_clear     restart the index at byte 0 (new schedule accepted)
//   i_advance   step to the next key byte, wrapping after KEY_BYTES-1
//   i_key_q     latched key, 8*KEY_BYTES bits
//   o_key_byte  key byte at the current index
// ----------------------------------------------------------------------------
module ksa_swap_fsm_key_byte_sel
  import ksa_swap_fsm_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_advance,
  input  logic [8*KEY_BYTES-1:0] i_key_q,
  output logic [7:0]             o_key_byte
);

  localparam int               IDX_W    = idx_width(KEY_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

  logic [IDX_W-1:0] r_key_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_idx <= '0;
    end else if (i_clear) begin
      r_key_idx <= '0;
    end else if (i_advance) begin
      r_key_idx <= (r_key_idx == IDX_LAST) ? '0 : r_key_idx + IDX_W'(1);
    end
  end

  // Constant-index part selects keep this a plain KEY_BYTES:1 byte mux.
  always_comb begin
    o_key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_key_idx == IDX_W'(k)) begin
        o_key_byte = i_key_q[8*(KEY_BYTES-k)-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/ksa_swap_fsm.sv
// ----------------------------------------------------------------------------
// ksa_swap_fsm
// RC4 key-scheduling (swap) phase. Runs after S has been initialised to
// S[i]=i; for i = 0..255 computes j = j + S[i] + key[i mod KEY_BYTES] and
// swaps S[i], S[j] through the single-port s_memory. Owns the memory while
// busy; done is a one-cycle hand-off pulse to the PRGA stage.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   start       run request, sampled only while idle
//   secret_key  key, byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8]
//   address     s_memory address
//   data        s_memory write data
//   wren        s_memory write enable
//   q           s_memory read data, valid one cycle after address
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the schedule completes
//
//   state  | meaning
//   IDLE   | waiting for start; key latched and i/j/key index cleared on accept
//   RD_SI  | address = i, read of S[i] in flight
//   CAP_SI | capture S[i], j += S[i] + key byte
//   RD_SJ  | address = j, read of S[j] in flight
//   CAP_SJ | capture S[j]
//   WR_I   | S[i] <= old S[j]
//   WR_J   | S[j] <= old S[i]
//   NXT    | advance i and key index, or finish after i = 255
//   DONE   | done pulse, still busy, back to IDLE
//
// All outputs are registered: the next-state logic computes the value each
// output must carry in the state being entered, so address/data/wren line up
// with the state they belong to and reset clears them immediately.
// ----------------------------------------------------------------------------
module ksa_swap_fsm
  import ksa_swap_fsm_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DFLT,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data,
  output logic                   wren,
  input  logic [DATA_W-1:0]      q,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(S_DEPTH - 1);

  ksa_state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]      r_i, w_i_nxt;
  logic [ADDR_W-1:0]      r_j, w_j_nxt;
  logic [DATA_W-1:0]      r_si_q, w_si_q_nxt;
  logic [8*KEY_BYTES-1:0] r_key_q, w_key_q_nxt;
  logic [ADDR_W-1:0]      r_address, w_address_nxt;
  logic [DATA_W-1:0]      r_data, w_data_nxt;
  logic                   r_wren, w_wren_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_key_clear;
  logic                   w_key_advance;
  logic [7:0]             w_key_byte;
  logic [ADDR_W-1:0]      w_j_sum;

  ksa_swap_fsm_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_byte_sel (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_clear    (w_key_clear),
    .i_advance  (w_key_advance),
    .i_key_q    (r_key_q),
    .o_key_byte (w_key_byte)
  );

  // j wraps freely modulo 2^ADDR_W.
  assign w_j_sum = r_j + ADDR_W'(q) + ADDR_W'(w_key_byte);

  always_comb begin
    w_state_nxt   = r_state;
    w_i_nxt       = r_i;
    w_j_nxt       = r_j;
    w_si_q_nxt    = r_si_q;
    w_key_q_nxt   = r_key_q;
    w_address_nxt = r_address;
    w_data_nxt    = r_data;
    w_wren_nxt    = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_key_clear   = 1'b0;
    w_key_advance = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = RD_SI;
          w_i_nxt       = '0;
          w_j_nxt       = '0;
          w_key_q_nxt   = secret_key;
          w_key_clear   = 1'b1;
          w_address_nxt = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      RD_SI: begin
        w_state_nxt = CAP_SI;
      end
      CAP_SI: begin
        w_si_q_nxt    = q;
        w_j_nxt       = w_j_sum;
        w_address_nxt = w_j_sum;
        w_state_nxt   = RD_SJ;
      end
      RD_SJ: begin
        w_state_nxt = CAP_SJ;
      end
      CAP_SJ: begin
        // The write-data register doubles as the S[j] capture.
        w_data_nxt    = q;
        w_address_nxt = r_i;
        w_wren_nxt    = 1'b1;
        w_state_nxt   = WR_I;
      end
      WR_I: begin
        w_data_nxt    = r_si_q;
        w_address_nxt = r_j;
        w_wren_nxt    = 1'b1;
        w_state_nxt   = WR_J;
      end
      WR_J: begin
        w_state_nxt = NXT;
      end
      NXT: begin
        if (r_i == I_LAST) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_i_nxt       = r_i + ADDR_W'(1);
          w_address_nxt = r_i + ADDR_W'(1);
          w_key_advance = 1'b1;
          w_state_nxt   = RD_SI;
        end
      end
      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_si_q    <= '0;
      r_key_q   <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      r_si_q    <= w_si_q_nxt;
      r_key_q   <= w_key_q_nxt;
      r_address <= w_address_nxt;
      r_data    <= w_data_nxt;
      r_wren    <= w_wren_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign address = r_address;
  assign data    = r_data;
  assign wren    = r_wren;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
